// File: rtl/pe_line_buffer.sv
// Raster-order line buffer feeding the PE array: emits one {r-2, r-1, r} pixel
// column per accepted pixel, plus window-complete and end-of-frame flags.
module pe_line_buffer #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  pixel_in,
  output logic [23:0] col_out,
  output logic        col_valid,
  output logic        win_valid,
  output logic        frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    line0_q [IMG_W];
  logic [7:0]    line1_q [IMG_W];
  logic [23:0]   col_out_d;
  logic          col_valid_d, win_valid_d, frame_done_d;
  logic          accept, last_col, last_row;

  assign accept   = in_valid && !clear;
  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    col_out_d    = col_out;
    col_valid_d  = 1'b0;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (in_valid) begin
      col_out_d    = {line1_q[col_q], line0_q[col_q], pixel_in};
      // Rows 0-1 still carry stale line data (previous frame or post-reset)
      col_valid_d  = (row_q >= RW'(2));
      win_valid_d  = (row_q >= RW'(2)) && (col_q >= CW'(2));
      frame_done_d = last_col && last_row;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q      <= '0;
      row_q      <= '0;
      col_out    <= '0;
      col_valid  <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      col_out    <= col_out_d;
      col_valid  <= col_valid_d;
      win_valid  <= win_valid_d;
      frame_done <= frame_done_d;
    end
  end

  // Line storage is deliberately unreset; the row-based masking hides it
  always_ff @(posedge clk) begin
    if (accept) begin
      line1_q[col_q] <= line0_q[col_q];
      line0_q[col_q] <= pixel_in;
    end
  end
endmodule

// File: tb/tb_pe_line_buffer.sv
// Randomized + directed bench for pe_line_buffer against a frame-image reference model.
module tb_pe_line_buffer;
  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [7:0]  pixel_in;
  logic [23:0] col_out;
  logic        col_valid, win_valid, frame_done;

  pe_line_buffer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .pixel_in(pixel_in), .col_out(col_out), .col_valid(col_valid),
    .win_valid(win_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: pixel index within the current frame and the frame image so far
  int          idx;
  logic [7:0]  img [H][W];
  logic [23:0] e_col;
  bit          col_known;
  bit          e_cv, e_wv, e_fd;
  int          n_cmp, n_bad;
  int          cnt_cv, cnt_wv, cnt_fd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("col_valid", {31'd0, col_valid}, {31'd0, e_cv});
    chk("win_valid", {31'd0, win_valid}, {31'd0, e_wv});
    chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
    if (col_known) chk("col_out", {8'd0, col_out}, {8'd0, e_col});
  endtask

  task automatic step(input bit v, input bit clr, input logic [7:0] px);
    int r, c;
    @(negedge clk);
    in_valid = v; clear = clr; pixel_in = px;
    @(posedge clk);
    e_cv = 0; e_wv = 0; e_fd = 0;
    if (clr) begin
      idx = 0;
    end else if (v) begin
      r = idx / W;
      c = idx % W;
      img[r][c] = px;
      e_cv = (r >= 2);
      e_wv = (r >= 2) && (c >= 2);
      e_fd = (idx == W*H - 1);
      if (r >= 2) begin
        e_col = {img[r-2][c], img[r-1][c], px};
        col_known = 1;
      end else begin
        col_known = 0;
      end
      idx = (idx + 1) % (W*H);
    end
    #1;
    check_outs();
    cnt_cv += int'(col_valid);
    cnt_wv += int'(win_valid);
    cnt_fd += int'(frame_done);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b0; in_valid = 1'b0; clear = 1'b0;
    #1;
    idx = 0; e_cv = 0; e_wv = 0; e_fd = 0; e_col = '0; col_known = 1;
    check_outs();
    #4 rst = 1'b1;
  endtask

  task automatic frame(input bit gapped, input string tag);
    cnt_cv = 0; cnt_wv = 0; cnt_fd = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, 1'b0, 8'(r*16 + c));
        if (gapped) step(1'b0, 1'b0, 8'hEE);
      end
    chk({tag, "_ncv"}, 32'(cnt_cv), 32'(2*W));
    chk({tag, "_nwv"}, 32'(cnt_wv), 32'(2*(W-2)));
    chk({tag, "_nfd"}, 32'(cnt_fd), 32'd1);
    chk({tag, "_last"}, {8'd0, col_out}, 32'h132333);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; pixel_in = '0;
    idx = 0; e_cv = 0; e_wv = 0; e_fd = 0; e_col = '0; col_known = 1;
    #12;
    check_outs();
    rst = 1'b1;

    frame(1'b0, "f1");
    // First streamed column of a back-to-back frame must reuse only this frame's rows
    for (int i = 0; i < 2*W; i++) step(1'b1, 1'b0, 8'((i/W)*16 + i%W));
    step(1'b1, 1'b0, 8'h20);
    chk("b2b_first", {8'd0, col_out}, 32'h001020);
    for (int i = 2*W + 1; i < W*H; i++) step(1'b1, 1'b0, 8'((i/W)*16 + i%W));
    frame(1'b1, "gap");

    // Clear together with a pixel at row 3, col 1
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 8'((i/W)*16 + i%W));
    step(1'b1, 1'b1, 8'h31);
    frame(1'b0, "clr");

    // Async reset mid-frame
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'((i/W)*16 + i%W));
    pulse_reset();
    frame(1'b0, "rst");

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else step(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
                8'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
